brush_ctrl: RTL and testbench
=============================

BRUSH_CTRL -- requirements
Module: brush_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameters SHALL be:
- H_RES, default 160, frame width in pixels.
- V_RES, default 120, frame height in pixels.
- BRUSH_R, default 1, brush radius; footprint is a (2R+1)x(2R+1) square.
- FIFO_DEPTH, default 4, stroke queue entries (power of 2).
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  sync active-high reset
- brushUpdate  in  1  level from SPI decoder; rising edge = new stroke
- x  in  8  stroke centre column
- y  in  8  stroke centre row
- newColorUpdate  in  3  colour from SPI decoder
- updateConfig  in  1  level; rising edge = latch newColorUpdate
- clearReq  in  1  pulse; request full-screen clear
- fbGnt  in  1  frame-buffer write grant from display arbiter
- fbReq  out  1  frame-buffer write request
- fbAddr  out  15  pixel address y*H_RES+x
- fbData  out  3  pixel colour
- busy  out  1  FSM not IDLE or FIFO non-empty
- overflow  out  1  sticky: stroke dropped

Function
REQ-004 SHALL edge-detect brushUpdate and updateConfig with a 1-cycle registered previous value; a level held high produces exactly one event.
REQ-005 An updateConfig edge SHALL latch newColorUpdate into curColor the same cycle.
REQ-006 A brushUpdate edge SHALL push {x, y, colour} into the FIFO. The colour is the new colour if an updateConfig edge occurs in the same cycle, otherwise curColor.
REQ-007 Push when FIFO is full SHALL be dropped and SHALL set overflow, even if a pop occurs the same cycle.
REQ-008 FSM states SHALL be IDLE, LOAD, PAINT, CLEAR.
REQ-009 IDLE -> CLEAR on pending clear (priority); else IDLE -> LOAD on FIFO non-empty; otherwise stay in IDLE.
REQ-010 LOAD SHALL pop one entry, set dx=dy=-BRUSH_R, and go to PAINT next cycle; first fbReq is 2 cycles after the push edge when the FIFO was empty.
REQ-011 PAINT SHALL scan dx fastest, then dy, from -R to +R; pixel = (x+dx, y+dy) computed as signed 10-bit.
REQ-012 An in-bounds pixel (0<=px<H_RES, 0<=py<V_RES) SHALL hold fbReq=1 with stable fbAddr/fbData until fbGnt=1. The write completes in that cycle and the scan advances next cycle.
REQ-013 An out-of-bounds pixel SHALL be skipped in one cycle with fbReq=0; no wrap-around.
REQ-014 After the last footprint pixel is written or skipped, the FSM SHALL return to IDLE.
REQ-015 fbReq SHALL be 0 in IDLE and LOAD; fbAddr and fbData are don't-care whenever fbReq=0.
REQ-016 A clearReq pulse SHALL set a pending flag. It is serviced only from IDLE; a stroke in progress completes first, and strokes queued meanwhile are kept.

Reset
REQ-017 On reset: state IDLE; FIFO empty; curColor=0; overflow=0; fbReq=0; busy=0; pending clear=0; edge-detect registers=0.
REQ-018 Reset asserted mid-stroke or mid-clear SHALL abort without further requests; the next cycle after deassertion is IDLE.

Configuration
REQ-019 Macro BRUSH_CTRL_CLEAR_EN SHALL compile in the CLEAR feature.
REQ-020 With BRUSH_CTRL_CLEAR_EN defined, CLEAR SHALL write colour 0 to addresses 0..H_RES*V_RES-1 in order, one per granted cycle, then return to IDLE and clear the pending flag.
REQ-021 Without BRUSH_CTRL_CLEAR_EN, the CLEAR state and pending flag SHALL not exist; the clearReq port remains and is ignored.

Structure
REQ-022 Package brush_pkg SHALL hold the state enum, color_t (3-bit), the stroke_t struct {x, y, color}, and the FB_AW=15 constant.
REQ-023 The FIFO SHALL be a separate sub-module, stroke_fifo: synchronous, registered count, full/empty flags, reset-clearable.
REQ-024 The controller FSM and the scan counters SHALL live in brush_ctrl.

Verification
REQ-025 Stroke at (10,20) with colour 5 and fbGnt tied 1 -> 9 writes, addresses 3049..3051, 3209..3211, 3369..3371, data 5; busy drops after the last write.
REQ-026 Stroke at (0,0) -> exactly 4 writes (addr 0, 1, 160, 161); 5 cycles skipped with fbReq=0.
REQ-027 fbGnt held 0 for 7 cycles at the first pixel -> fbReq and fbAddr stable for all 7 cycles; no scan advance.
REQ-028 5 brushUpdate edges in consecutive-edge spacing while fbGnt=0 -> 4 queued, overflow=1, fifth dropped; releasing fbGnt paints 4 strokes.
REQ-029 updateConfig and brushUpdate edges in the same cycle with newColorUpdate=3 -> stroke painted with 3.
REQ-030 With BRUSH_CTRL_CLEAR_EN: clearReq during a stroke -> stroke finishes, then 19200 writes of 0. Reset mid-clear -> fbReq=0 the next cycle and IDLE.

Source files
------------

// File: rtl/brush_pkg.sv
// Shared types for the brush controller: FSM states, pixel colour, queued stroke record.
// The CLEAR state only exists when BRUSH_CTRL_CLEAR_EN is defined.
package brush_pkg;

   localparam int FB_AW = 15;

   typedef logic [2:0] color_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      color_t     color;
   } stroke_t;

`ifdef BRUSH_CTRL_CLEAR_EN
   typedef enum logic [1:0] {IDLE, LOAD, PAINT, CLEAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, PAINT} state_t;
`endif

endpackage

// File: rtl/stroke_fifo.sv
// Stroke queue: synchronous show-ahead FIFO, write visible on dout the cycle after push.
// Push while full and pop while empty are ignored; the caller flags dropped pushes.
module stroke_fifo
   import brush_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  stroke_t din,
   input  logic    pop,
   output stroke_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   stroke_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/brush_ctrl.sv
// Paints queued brush strokes into the frame buffer; first fbReq two cycles after the push edge,
// each in-bounds pixel held until fbGnt. BRUSH_CTRL_CLEAR_EN adds the full-screen CLEAR sweep.
module brush_ctrl
   import brush_pkg::*;
#(
   parameter int H_RES      = 160,
   parameter int V_RES      = 120,
   parameter int BRUSH_R    = 1,
   parameter int FIFO_DEPTH = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             brushUpdate,
   input  logic [7:0]       x,
   input  logic [7:0]       y,
   input  logic [2:0]       newColorUpdate,
   input  logic             updateConfig,
   input  logic             clearReq,
   input  logic             fbGnt,
   output logic             fbReq,
   output logic [FB_AW-1:0] fbAddr,
   output logic [2:0]       fbData,
   output logic             busy,
   output logic             overflow
);

   // Offsets and pixel coordinates are 10-bit two's complement; bit 9 marks a negative value.
   localparam logic [9:0] RAD   = 10'(BRUSH_R);
   localparam logic [9:0] NEG_R = ~RAD + 10'd1;
   localparam logic [9:0] H_LIM = 10'(H_RES);
   localparam logic [9:0] V_LIM = 10'(V_RES);

   state_t           state;
   state_t           state_nxt;
   logic             brush_prev;
   logic             cfg_prev;
   logic             brush_edge;
   logic             cfg_edge;
   color_t           cur_color;
   stroke_t          push_dat;
   stroke_t          fifo_dout;
   stroke_t          cur;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [9:0]       dx;
   logic [9:0]       dy;
   logic [9:0]       px;
   logic [9:0]       py;
   logic             in_bounds;
   logic             advance;
   logic [FB_AW-1:0] pix_addr;

   assign brush_edge = brushUpdate && !brush_prev;
   assign cfg_edge   = updateConfig && !cfg_prev;

   // A colour change arriving with the stroke edge applies to that stroke.
   assign push_dat.x     = x;
   assign push_dat.y     = y;
   assign push_dat.color = cfg_edge ? newColorUpdate : cur_color;

   assign px        = {2'b00, cur.x} + dx;
   assign py        = {2'b00, cur.y} + dy;
   assign in_bounds = !px[9] && !py[9] && (px < H_LIM) && (py < V_LIM);
   assign pix_addr  = FB_AW'(py) * FB_AW'(H_RES) + FB_AW'(px);

   assign busy = (state != IDLE) || !fifo_empty;

   stroke_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (brush_edge),
      .din   (push_dat),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef BRUSH_CTRL_CLEAR_EN
   localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(H_RES * V_RES - 1);

   logic             clr_pend;
   logic             clr_done;
   logic [FB_AW-1:0] clr_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         clr_pend <= 1'b0;
         clr_addr <= '0;
      end else begin
         clr_pend <= (clr_pend && !clr_done) || clearReq;
         if (state != CLEAR) clr_addr <= '0;
         else if (fbGnt)     clr_addr <= clr_addr + FB_AW'(1);
      end
   end
`else
   logic unused_clear_req;
   assign unused_clear_req = clearReq;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fbReq     = 1'b0;
      fbAddr    = '0;
      fbData    = '0;
      fifo_pop  = 1'b0;
      advance   = 1'b0;
`ifdef BRUSH_CTRL_CLEAR_EN
      clr_done  = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef BRUSH_CTRL_CLEAR_EN
            if (clr_pend)         state_nxt = CLEAR;
            else if (!fifo_empty) state_nxt = LOAD;
`else
            if (!fifo_empty)      state_nxt = LOAD;
`endif
         end
         LOAD: begin
            fifo_pop  = 1'b1;
            state_nxt = PAINT;
         end
         PAINT: begin
            fbReq   = in_bounds;
            fbAddr  = pix_addr;
            fbData  = cur.color;
            advance = !in_bounds || fbGnt;
            if (advance && (dx == RAD) && (dy == RAD)) state_nxt = IDLE;
         end
`ifdef BRUSH_CTRL_CLEAR_EN
         CLEAR: begin
            fbReq  = 1'b1;
            fbAddr = clr_addr;
            if (fbGnt && (clr_addr == CLR_LAST)) begin
               clr_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         brush_prev <= 1'b0;
         cfg_prev   <= 1'b0;
         cur_color  <= '0;
         overflow   <= 1'b0;
         cur        <= '0;
         dx         <= '0;
         dy         <= '0;
      end else begin
         brush_prev <= brushUpdate;
         cfg_prev   <= updateConfig;
         if (cfg_edge) cur_color <= newColorUpdate;
         if (brush_edge && fifo_full) overflow <= 1'b1;
         if (fifo_pop) begin
            cur <= fifo_dout;
            dx  <= NEG_R;
            dy  <= NEG_R;
         end else if (advance) begin
            if (dx == RAD) begin
               dx <= NEG_R;
               dy <= dy + 10'd1;
            end else begin
               dx <= dx + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_brush_ctrl.sv
// Scoreboard bench for brush_ctrl: expected frame-buffer writes are queued when a stroke is driven
// and popped on every granted fbReq. Define BRUSH_CTRL_CLEAR_EN to also exercise the clear sweep.
module tb_brush_ctrl;

   localparam int H = 160;
   localparam int V = 120;
   localparam int R = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        brushUpdate;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [2:0]  newColorUpdate;
   logic        updateConfig;
   logic        clearReq;
   logic        fbGnt;
   logic        fbReq;
   logic [14:0] fbAddr;
   logic [2:0]  fbData;
   logic        busy;
   logic        overflow;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [17:0] sb_q [$];
   logic [17:0] mon_e;
   int          wr_cnt     = 0;
   int          first_addr = 0;
   int          last_addr  = 0;
   int          idle_skip  = 0;

   always #5 clk = ~clk;

   brush_ctrl #(
      .H_RES      (H),
      .V_RES      (V),
      .BRUSH_R    (R),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .brushUpdate    (brushUpdate),
      .x              (x),
      .y              (y),
      .newColorUpdate (newColorUpdate),
      .updateConfig   (updateConfig),
      .clearReq       (clearReq),
      .fbGnt          (fbGnt),
      .fbReq          (fbReq),
      .fbAddr         (fbAddr),
      .fbData         (fbData),
      .busy           (busy),
      .overflow       (overflow)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic void expect_stroke(input int cx, input int cy, input int c);
      for (int j = -R; j <= R; j++) begin
         for (int i = -R; i <= R; i++) begin
            int qx;
            int qy;
            qx = cx + i;
            qy = cy + j;
            if (qx >= 0 && qx < H && qy >= 0 && qy < V)
               sb_q.push_back({15'(qy * H + qx), 3'(c)});
         end
      end
   endfunction

   // Write monitor samples on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (!reset && fbReq && fbGnt) begin
         check("sb_has_exp", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("wr_addr", fbAddr, mon_e[17:3]);
            check("wr_data", fbData, mon_e[2:0]);
         end
         if (wr_cnt == 0) first_addr = fbAddr;
         last_addr = fbAddr;
         wr_cnt++;
      end
      if (!reset && busy && !fbReq) idle_skip++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stroke(input int sx, input int sy, input bit cfg, input int c);
      x           = 8'(sx);
      y           = 8'(sy);
      brushUpdate = 1'b1;
      if (cfg) begin
         updateConfig   = 1'b1;
         newColorUpdate = 3'(c);
      end
      tick();
      brushUpdate  = 1'b0;
      updateConfig = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit, output int n);
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!fbReq && n < 20) begin
         tick();
         n++;
      end
      check(tag, fbReq, 1);
   endtask

   initial begin
      int    k;
      int    n;
      logic [14:0] a0;

      reset          = 1'b1;
      brushUpdate    = 1'b0;
      updateConfig   = 1'b0;
      clearReq       = 1'b0;
      newColorUpdate = 3'd0;
      x              = 8'd0;
      y              = 8'd0;
      fbGnt          = 1'b1;
      tick();
      tick();
      check("rst_fbReq", fbReq, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);

      // Colour 5, then a stroke at (10,20) with grant tied high.
      updateConfig   = 1'b1;
      newColorUpdate = 3'd5;
      tick();
      updateConfig = 1'b0;
      tick();
      wr_cnt = 0;
      expect_stroke(10, 20, 5);
      stroke(10, 20, 1'b0, 0);
      k = 0;
      while (!fbReq && k < 10) begin
         tick();
         k++;
      end
      check("first_req_latency", k, 2);
      wait_idle("idle_10_20", 50, n);
      check("busy_drop_cycles", n, 9);
      check("writes_10_20", wr_cnt, 9);
      check("first_addr_10_20", first_addr, 3049);
      check("last_addr_10_20", last_addr, 3371);
      check("sb_drained_10_20", sb_q.size(), 0);

      // Top-left corner: five footprint pixels are skipped.
      wr_cnt    = 0;
      idle_skip = 0;
      expect_stroke(0, 0, 5);
      stroke(0, 0, 1'b0, 0);
      wait_idle("idle_0_0", 50, n);
      check("writes_0_0", wr_cnt, 4);
      check("nonreq_busy_cycles_0_0", idle_skip, 7);

      // Bottom-right corner: x=160 and y=120 are out of bounds.
      wr_cnt = 0;
      expect_stroke(159, 119, 5);
      stroke(159, 119, 1'b0, 0);
      wait_idle("idle_159_119", 50, n);
      check("writes_159_119", wr_cnt, 4);
      check("last_addr_159_119", last_addr, 119 * 160 + 159);

      // Grant withheld for 7 cycles on the first pixel.
      fbGnt = 1'b0;
      expect_stroke(50, 50, 5);
      stroke(50, 50, 1'b0, 0);
      wait_req("stall_req_seen");
      a0 = fbAddr;
      check("stall_first_addr", a0, 49 * 160 + 49);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("stall_req", fbReq, 1);
         check("stall_addr", fbAddr, a0);
      end
      fbGnt = 1'b1;
      wait_idle("idle_stall", 50, n);
      check("sb_drained_stall", sb_q.size(), 0);

      // Stroke A stalled in PAINT, then five edges: four queued, fifth dropped.
      check("ovf_before", overflow, 0);
      fbGnt  = 1'b0;
      wr_cnt = 0;
      expect_stroke(30, 30, 5);
      stroke(30, 30, 1'b0, 0);
      wait_req("ovf_a_req");
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check("ovf_after_4", overflow, 0);
         if (i < 4) expect_stroke(40 + 10 * i, 60, 5);
         x           = 8'(40 + 10 * i);
         y           = 8'd60;
         brushUpdate = 1'b1;
         tick();
         brushUpdate = 1'b0;
         tick();
      end
      check("ovf_after_5", overflow, 1);
      fbGnt = 1'b1;
      wait_idle("idle_ovf", 300, n);
      check("writes_ovf", wr_cnt, 45);
      check("sb_drained_ovf", sb_q.size(), 0);
      check("ovf_sticky", overflow, 1);

      // Colour change in the same cycle as the stroke edge, then a stroke that reuses it.
      expect_stroke(100, 100, 3);
      stroke(100, 100, 1'b1, 3);
      wait_idle("idle_cfg", 50, n);
      expect_stroke(120, 50, 3);
      stroke(120, 50, 1'b0, 0);
      wait_idle("idle_cfg2", 50, n);
      check("sb_drained_cfg", sb_q.size(), 0);

      // Reset mid-stroke aborts and restores defaults.
      fbGnt = 1'b0;
      stroke(70, 70, 1'b0, 0);
      wait_req("abort_req_seen");
      reset = 1'b1;
      tick();
      check("abort_req_in_rst", fbReq, 0);
      reset = 1'b0;
      sb_q.delete();
      tick();
      check("abort_req", fbReq, 0);
      check("abort_busy", busy, 0);
      check("abort_ovf", overflow, 0);
      fbGnt  = 1'b1;
      wr_cnt = 0;
      expect_stroke(5, 5, 0);
      stroke(5, 5, 1'b0, 0);
      wait_idle("idle_post_abort", 50, n);
      check("writes_post_abort", wr_cnt, 9);
      check("sb_drained_abort", sb_q.size(), 0);

`ifdef BRUSH_CTRL_CLEAR_EN
      // Clear requested during a stroke: stroke completes, then the full sweep of colour 0.
      wr_cnt = 0;
      expect_stroke(20, 20, 0);
      stroke(20, 20, 1'b0, 0);
      wait_req("clr_stroke_req");
      clearReq = 1'b1;
      tick();
      clearReq = 1'b0;
      for (int i = 0; i < H * V; i++) sb_q.push_back({15'(i), 3'd0});
      n = 0;
      while (sb_q.size() > 0 && n < 25000) begin
         tick();
         n++;
      end
      check("clr_sb_drained", sb_q.size(), 0);
      tick();
      tick();
      check("clr_writes", wr_cnt, 9 + H * V);
      check("clr_done_req", fbReq, 0);
      check("clr_done_busy", busy, 0);

      // Reset in the middle of a clear sweep.
      for (int i = 0; i < H * V; i++) sb_q.push_back({15'(i), 3'd0});
      clearReq = 1'b1;
      tick();
      clearReq = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("clr_mid_req", fbReq, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_q.delete();
      check("clr_rst_req", fbReq, 0);
      tick();
      check("clr_rst_req2", fbReq, 0);
      check("clr_rst_busy", busy, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
